clic_irq_arbiter: RTL and testbench

CLIC_IRQ_ARBITER -- requirements
Module: clic_irq_arbiter

---
 rtl/clic_irq_arbiter.sv | 178 +++++++++++++++++
 tb/tb_clic_irq_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/clic_irq_arbiter.sv
// CLIC-style interrupt arbiter: per-source config, level/edge pending,
// {mode,level} priority with lowest-id tie-break, registered offer/claim FSM.
module clic_irq_arbiter #(
    parameter int unsigned NUM_IRQ = 16,
    parameter bit          SYNC_IN = 1'b1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               cfg_we,
    input  logic [7:0]         cfg_idx,
    input  logic               cfg_ie,
    input  logic               cfg_edge,
    input  logic               cfg_shv,
    input  logic [1:0]         cfg_mode,
    input  logic [7:0]         cfg_level,
    input  logic [7:0]         thresh,
    input  logic               irq_ack,
    output logic               irq_valid,
    output logic [1:0]         mode,
    output logic [7:0]         level,
    output logic               is_vectored,
    output logic [7:0]         id
);

    typedef enum logic [1:0] {IDLE, OFFER, CLAIM} state_t;

    state_t state_q, state_d;

    logic [NUM_IRQ-1:0] ie_q, edge_q, shv_q;
    logic [1:0]         cmode_q  [NUM_IRQ];
    logic [7:0]         clevel_q [NUM_IRQ];

    logic [NUM_IRQ-1:0] irq_s, irq_p_q, rise;
    logic [NUM_IRQ-1:0] epend_q, epend_d, pend, cand;

    logic       found, qualify, claim;
    logic [9:0] best_key;
    logic [7:0] best_idx;
    logic       best_shv;

    logic       valid_q, valid_d;
    logic [1:0] omode_q, omode_d;
    logic [7:0] olevel_q, olevel_d;
    logic       oshv_q, oshv_d;
    logic [7:0] oid_q, oid_d;

    // Optional input sampling stage ahead of the pending logic
    generate
        if (SYNC_IN) begin : g_sync
            logic [NUM_IRQ-1:0] sync_q;
            // Register raw lines once
            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) sync_q <= '0;
                else          sync_q <= irq_in;
            end
            assign irq_s = sync_q;
        end else begin : g_nosync
            assign irq_s = irq_in;
        end
    endgenerate

    // Per-source configuration; indices beyond NUM_IRQ never match
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ie_q   <= '0;
            edge_q <= '0;
            shv_q  <= '0;
            for (int i = 0; i < NUM_IRQ; i++) begin
                cmode_q[i]  <= 2'd0;
                clevel_q[i] <= 8'd0;
            end
        end else if (cfg_we) begin
            for (int i = 0; i < NUM_IRQ; i++) begin
                if (cfg_idx == 8'(i)) begin
                    ie_q[i]     <= cfg_ie;
                    edge_q[i]   <= cfg_edge;
                    shv_q[i]    <= cfg_shv;
                    cmode_q[i]  <= cfg_mode;
                    clevel_q[i] <= cfg_level;
                end
            end
        end
    end

    // Pending: level follows the sample, edge latches until claimed (set wins)
    always_comb begin
        rise    = irq_s & ~irq_p_q;
        epend_d = '0;
        pend    = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            epend_d[i] = edge_q[i] & (rise[i] |
                         (epend_q[i] & ~(claim && oid_q == 8'(i))));
            pend[i]    = edge_q[i] ? epend_q[i] : irq_s[i];
        end
        cand = pend & ie_q;
    end

    // Priority search: strictly greater key replaces, so ties keep lowest id
    always_comb begin
        found    = 1'b0;
        best_key = 10'd0;
        best_idx = 8'd0;
        best_shv = 1'b0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (cand[i] && (!found || {cmode_q[i], clevel_q[i]} > best_key)) begin
                found    = 1'b1;
                best_key = {cmode_q[i], clevel_q[i]};
                best_idx = 8'(i);
                best_shv = shv_q[i];
            end
        end
        qualify = found && (best_key[7:0] > thresh);
    end

    // Offer FSM next state and next registered outputs
    always_comb begin
        state_d  = state_q;
        claim    = 1'b0;
        valid_d  = 1'b0;
        omode_d  = 2'd0;
        olevel_d = 8'd0;
        oshv_d   = 1'b0;
        oid_d    = 8'd0;
        unique case (state_q)
            IDLE: begin
                if (qualify) state_d = OFFER;
            end
            OFFER: begin
                if (irq_ack) begin
                    claim   = 1'b1;
                    state_d = CLAIM;
                end else if (!qualify) begin
                    state_d = IDLE;
                end
            end
            CLAIM: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_d == OFFER) begin
            valid_d  = 1'b1;
            omode_d  = best_key[9:8];
            olevel_d = best_key[7:0];
            oshv_d   = best_shv;
            oid_d    = best_idx;
        end
    end

    // State, output, pending and edge-history registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            omode_q  <= 2'd0;
            olevel_q <= 8'd0;
            oshv_q   <= 1'b0;
            oid_q    <= 8'd0;
            epend_q  <= '0;
            irq_p_q  <= '0;
        end else begin
            state_q  <= state_d;
            valid_q  <= valid_d;
            omode_q  <= omode_d;
            olevel_q <= olevel_d;
            oshv_q   <= oshv_d;
            oid_q    <= oid_d;
            epend_q  <= epend_d;
            irq_p_q  <= irq_s;
        end
    end

    assign irq_valid   = valid_q;
    assign mode        = omode_q;
    assign level       = olevel_q;
    assign is_vectored = oshv_q;
    assign id          = oid_q;

endmodule

// File: tb/tb_clic_irq_arbiter.sv
// Directed bench for clic_irq_arbiter: offers, priority, threshold,
// edge claim race, disable/re-enable, stray ack, out-of-range write, reset.
module tb_clic_irq_arbiter;

    localparam int N = 16;

    logic         clock = 1'b0;
    logic         reset_n = 1'b1;
    logic [N-1:0] irq_in = '0;
    logic         cfg_we = 1'b0;
    logic [7:0]   cfg_idx = 8'd0;
    logic         cfg_ie = 1'b0;
    logic         cfg_edge = 1'b0;
    logic         cfg_shv = 1'b0;
    logic [1:0]   cfg_mode = 2'd0;
    logic [7:0]   cfg_level = 8'd0;
    logic [7:0]   thresh = 8'h10;
    logic         irq_ack = 1'b0;
    logic         irq_valid;
    logic [1:0]   mode;
    logic [7:0]   level;
    logic         is_vectored;
    logic [7:0]   id;

    int n_cmp = 0;
    int n_err = 0;

    clic_irq_arbiter #(.NUM_IRQ(N), .SYNC_IN(1'b1)) dut (
        .clock(clock), .reset_n(reset_n), .irq_in(irq_in),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_ie(cfg_ie),
        .cfg_edge(cfg_edge), .cfg_shv(cfg_shv), .cfg_mode(cfg_mode),
        .cfg_level(cfg_level), .thresh(thresh), .irq_ack(irq_ack),
        .irq_valid(irq_valid), .mode(mode), .level(level),
        .is_vectored(is_vectored), .id(id)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    function automatic logic [31:0] ex(input logic v, input logic [1:0] m,
                                       input logic [7:0] l, input logic s,
                                       input logic [7:0] i);
        return {12'd0, v, m, l, s, i};
    endfunction

    function automatic logic [31:0] obs();
        return {12'd0, irq_valid, mode, level, is_vectored, id};
    endfunction

    task automatic check(input string tag, input logic [31:0] o,
                         input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic cfg(input logic [7:0] idx, input logic ie, input logic ed,
                       input logic sv, input logic [1:0] md,
                       input logic [7:0] lv);
        cfg_we = 1'b1; cfg_idx = idx; cfg_ie = ie; cfg_edge = ed;
        cfg_shv = sv; cfg_mode = md; cfg_level = lv;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!irq_valid && n < 8) begin
            tick();
            n++;
        end
        check(tag, 32'(irq_valid), 32'd1);
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        #2 reset_n = 1'b0;
        #1 check("reset", obs(), 32'd0);
        @(negedge clock);
        ticks(2);
        reset_n = 1'b1;
        tick();

        // single level source
        cfg(8'd3, 1'b1, 1'b0, 1'b0, 2'd3, 8'h40);
        irq_in[3] = 1'b1;
        tick();
        check("lat_early", obs(), 32'd0);
        tick();
        check("single", obs(), ex(1'b1, 2'd3, 8'h40, 1'b0, 8'd3));
        irq_in[3] = 1'b0;
        ticks(2);
        check("single_drop", obs(), 32'd0);

        // priority, tie and preemption
        cfg(8'd5, 1'b1, 1'b0, 1'b0, 2'd3, 8'h80);
        cfg(8'd2, 1'b1, 1'b0, 1'b1, 2'd3, 8'h80);
        cfg(8'd9, 1'b1, 1'b0, 1'b0, 2'd3, 8'h90);
        irq_in[5] = 1'b1;
        irq_in[2] = 1'b1;
        ticks(2);
        check("tie", obs(), ex(1'b1, 2'd3, 8'h80, 1'b1, 8'd2));
        irq_in[9] = 1'b1;
        tick();
        check("pre9", obs(), ex(1'b1, 2'd3, 8'h80, 1'b1, 8'd2));
        tick();
        check("preempt", obs(), ex(1'b1, 2'd3, 8'h90, 1'b0, 8'd9));
        irq_in = '0;
        ticks(2);
        check("prio_drop", obs(), 32'd0);

        // threshold is strict
        cfg(8'd1, 1'b1, 1'b0, 1'b0, 2'd3, 8'h20);
        thresh = 8'h20;
        irq_in[1] = 1'b1;
        ticks(3);
        check("thr_eq", obs(), 32'd0);
        thresh = 8'h1F;
        tick();
        check("thr_gt", obs(), ex(1'b1, 2'd3, 8'h20, 1'b0, 8'd1));

        // level source claimed while high is re-offered
        ack();
        check("lvl_claim", 32'(irq_valid), 32'd0);
        wait_valid("lvl_reoffer");
        check("lvl_reid", obs(), ex(1'b1, 2'd3, 8'h20, 1'b0, 8'd1));
        irq_in[1] = 1'b0;
        ticks(2);
        check("lvl_drop", obs(), 32'd0);

        // edge source: claim clears pending
        cfg(8'd4, 1'b1, 1'b1, 1'b0, 2'd3, 8'h50);
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        wait_valid("e_offer");
        check("e_fields", obs(), ex(1'b1, 2'd3, 8'h50, 1'b0, 8'd4));
        ack();
        check("e_claim", obs(), 32'd0);
        ticks(3);
        check("e_cleared", obs(), 32'd0);

        // edge source: new rise in the claim cycle keeps pending
        irq_in[4] = 1'b1;
        tick();
        irq_in[4] = 1'b0;
        wait_valid("race_offer");
        irq_in[4] = 1'b1;
        tick();
        irq_ack = 1'b1;
        irq_in[4] = 1'b0;
        tick();
        irq_ack = 1'b0;
        check("race_claim", obs(), 32'd0);
        wait_valid("race_reoffer");
        check("race_id", obs(), ex(1'b1, 2'd3, 8'h50, 1'b0, 8'd4));

        // disable keeps edge pending; stray ack while idle is ignored
        cfg(8'd4, 1'b0, 1'b1, 1'b0, 2'd3, 8'h50);
        tick();
        check("disabled", obs(), 32'd0);
        ack();
        tick();
        check("stray_ack", obs(), 32'd0);
        cfg(8'd4, 1'b1, 1'b1, 1'b0, 2'd3, 8'h50);
        wait_valid("reenable");
        check("reen_id", obs(), ex(1'b1, 2'd3, 8'h50, 1'b0, 8'd4));
        ack();
        ticks(3);
        check("final_clr", obs(), 32'd0);

        // out-of-range config write is ignored
        cfg(8'(N), 1'b1, 1'b0, 1'b1, 2'd3, 8'hFF);
        irq_in[0] = 1'b1;
        ticks(3);
        check("oor_write", obs(), 32'd0);
        irq_in[0] = 1'b0;

        // reset while offering
        cfg(8'd7, 1'b1, 1'b0, 1'b0, 2'd1, 8'h60);
        irq_in[7] = 1'b1;
        wait_valid("r_offer");
        check("r_fields", obs(), ex(1'b1, 2'd1, 8'h60, 1'b0, 8'd7));
        reset_n = 1'b0;
        #1 check("r_async", obs(), 32'd0);
        @(negedge clock);
        tick();
        reset_n = 1'b1;
        ticks(4);
        check("r_cfg_clr", obs(), 32'd0);
        cfg(8'd7, 1'b1, 1'b0, 1'b0, 2'd1, 8'h60);
        wait_valid("r_reconf");
        check("r_reid", obs(), ex(1'b1, 2'd1, 8'h60, 1'b0, 8'd7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
